// File: rtl/cache_data_array_sa.sv
// -----------------------------------------------------------------------------
// cache_data_array_sa
//   Set-associative data store for the data cache. The controller picks the
//   way; the array serves CPU word reads, byte-masked CPU updates and
//   full-line refills. A dirty bit is kept per line, and on refill the line
//   being replaced is presented to the write-back path. Clearing walks the
//   sets one per cycle under a small FSM and raises busy while it runs.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   clr           start a clear sweep (pulse or level)
//   address       CPU byte address (byte offset | word | index | ignored tag)
//   way_sel       target way chosen by the controller
//   read_req      read the addressed word
//   update_req    byte-masked write of wdata under wstrb
//   refill_req    replace the whole addressed line with data_mem
//   wdata, wstrb  CPU write data and byte enables
//   data_mem      refill line from main memory
//   rdata/rvalid  registered read data and its one-cycle valid pulse
//   ack           one-cycle pulse after an update or refill commits
//   evict_data    prior contents of the line replaced by the last refill
//   evict_dirty   that line was dirty and needs write-back
//   busy          clear sweep in progress
//
// WORDS_PER_LINE and NUM_SETS are expected to be powers of two >= 2.
// -----------------------------------------------------------------------------
module cache_data_array_sa #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_SETS       = 4,
    parameter int NUM_WAYS       = 2,
    localparam int LINE_WIDTH    = WORD_WIDTH * WORDS_PER_LINE,
    localparam int WAY_BITS      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int STRB_WIDTH    = WORD_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WAY_BITS-1:0]   way_sel,
    input  logic                  read_req,
    input  logic                  update_req,
    input  logic                  refill_req,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic [LINE_WIDTH-1:0] data_mem,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  ack,
    output logic [LINE_WIDTH-1:0] evict_data,
    output logic                  evict_dirty,
    output logic                  busy
);

    localparam int BYTE_BITS  = $clog2(STRB_WIDTH);
    localparam int WORD_BITS  = $clog2(WORDS_PER_LINE);
    localparam int INDEX_BITS = $clog2(NUM_SETS);
    localparam int USED_BITS  = BYTE_BITS + WORD_BITS + INDEX_BITS;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Write the enabled bytes of wd into word w of line, leaving the rest.
    function automatic logic [LINE_WIDTH-1:0] merge_bytes(
        input logic [LINE_WIDTH-1:0] line,
        input logic [WORD_BITS-1:0]  w,
        input logic [WORD_WIDTH-1:0] wd,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [LINE_WIDTH-1:0] res;
        res = line;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            res[int'(w) * WORD_WIDTH + b * 8 +: 8] =
                strb[b] ? wd[b * 8 +: 8] : line[int'(w) * WORD_WIDTH + b * 8 +: 8];
        end
        return res;
    endfunction

    state_e state_q, state_d;
    logic [INDEX_BITS-1:0] clr_cnt_q, clr_cnt_d;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0][LINE_WIDTH-1:0] mem_q, mem_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]                 dirty_q, dirty_d;

    logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  ack_q, ack_d;
    logic [LINE_WIDTH-1:0] evict_data_q, evict_data_d;
    logic                  evict_dirty_q, evict_dirty_d;
    logic                  busy_q, busy_d;

    logic [WORD_BITS-1:0]  word_s;
    logic [INDEX_BITS-1:0] index_s;
    logic                  addr_unused_s;

    assign word_s  = address[BYTE_BITS +: WORD_BITS];
    assign index_s = address[BYTE_BITS + WORD_BITS +: INDEX_BITS];
    // Byte offset and tag bits carry no meaning for the data array.
    assign addr_unused_s = ^{address[ADDR_WIDTH-1:USED_BITS], address[BYTE_BITS-1:0]};

    // Next-state, storage update and output computation for both FSM states.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        mem_d         = mem_q;
        dirty_d       = dirty_q;
        rdata_d       = rdata_q;
        rvalid_d      = 1'b0;
        ack_d         = 1'b0;
        evict_data_d  = evict_data_q;
        evict_dirty_d = evict_dirty_q;

        case (state_q)
            ST_IDLE: begin
                // Fixed priority; anything below the winner is dropped.
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (refill_req) begin
                    evict_data_d              = mem_q[index_s][way_sel];
                    evict_dirty_d             = dirty_q[index_s][way_sel];
                    mem_d[index_s][way_sel]   = data_mem;
                    dirty_d[index_s][way_sel] = 1'b0;
                    ack_d                     = 1'b1;
                end else if (update_req) begin
                    // A zero strobe still marks the line dirty.
                    mem_d[index_s][way_sel]   = merge_bytes(mem_q[index_s][way_sel],
                                                            word_s, wdata, wstrb);
                    dirty_d[index_s][way_sel] = 1'b1;
                    ack_d                     = 1'b1;
                end else if (read_req) begin
                    rdata_d  = mem_q[index_s][way_sel][int'(word_s) * WORD_WIDTH +: WORD_WIDTH];
                    rvalid_d = 1'b1;
                end else begin
                    rvalid_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                // One set per cycle; all requests are ignored meanwhile.
                mem_d[clr_cnt_q]   = '0;
                dirty_d[clr_cnt_q] = '0;
                if (clr_cnt_q == INDEX_BITS'(NUM_SETS - 1)) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + INDEX_BITS'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase

        // busy tracks the registered FSM state so it is high for exactly the sweep.
        busy_d = (state_d == ST_CLEAR);
    end

    // State, storage and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            clr_cnt_q     <= '0;
            mem_q         <= '0;
            dirty_q       <= '0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            ack_q         <= 1'b0;
            evict_data_q  <= '0;
            evict_dirty_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            mem_q         <= mem_d;
            dirty_q       <= dirty_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            ack_q         <= ack_d;
            evict_data_q  <= evict_data_d;
            evict_dirty_q <= evict_dirty_d;
            busy_q        <= busy_d;
        end
    end

    assign rdata       = rdata_q;
    assign rvalid      = rvalid_q;
    assign ack         = ack_q;
    assign evict_data  = evict_data_q;
    assign evict_dirty = evict_dirty_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_cache_data_array_sa.sv
// -----------------------------------------------------------------------------
// tb_cache_data_array_sa
//   Bench for cache_data_array_sa with default parameters. A word-level model
//   (arrays of words and dirty flags, clear treated as instantaneous zeroing
//   plus a busy countdown) predicts every registered output each cycle.
// -----------------------------------------------------------------------------
module tb_cache_data_array_sa;

    localparam int NS = 4;
    localparam int NW = 2;
    localparam int WPL = 4;

    logic         clk;
    logic         rst;
    logic         clr;
    logic [31:0]  address;
    logic [0:0]   way_sel;
    logic         read_req;
    logic         update_req;
    logic         refill_req;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic [127:0] data_mem;
    logic [31:0]  rdata;
    logic         rvalid;
    logic         ack;
    logic [127:0] evict_data;
    logic         evict_dirty;
    logic         busy;

    cache_data_array_sa dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .address     (address),
        .way_sel     (way_sel),
        .read_req    (read_req),
        .update_req  (update_req),
        .refill_req  (refill_req),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .data_mem    (data_mem),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .ack         (ack),
        .evict_data  (evict_data),
        .evict_dirty (evict_dirty),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0]  m_word  [NS][NW][WPL];
    logic         m_dirty [NS][NW];
    int           m_busy_left;
    logic [31:0]  e_rdata;
    logic         e_rvalid;
    logic         e_ack;
    logic [127:0] e_evict_data;
    logic         e_evict_dirty;

    int n_vec;
    int n_miss;

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_dirty[s][w] = 1'b0;
                for (int k = 0; k < WPL; k++) m_word[s][w][k] = 32'h0;
            end
    endtask

    // Apply one cycle of inputs, advance the model, then check all outputs.
    task automatic cycle(input logic r, input logic c, input logic rd, input logic up,
                         input logic rf, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] st, input logic [127:0] dm);
        int s;
        int k;
        rst = r; clr = c; read_req = rd; update_req = up; refill_req = rf;
        address = a; way_sel = w; wdata = wd; wstrb = st; data_mem = dm;
        @(posedge clk);
        s = (a / 16) % NS;
        k = (a / 4) % WPL;
        e_rvalid = 1'b0;
        e_ack = 1'b0;
        if (r) begin
            model_zero();
            m_busy_left = 0;
            e_rdata = 32'h0;
            e_evict_data = 128'h0;
            e_evict_dirty = 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (c) begin
            model_zero();
            m_busy_left = NS;
        end else if (rf) begin
            for (int i = 0; i < WPL; i++) begin
                e_evict_data[i*32 +: 32] = m_word[s][w][i];
                m_word[s][w][i] = dm[i*32 +: 32];
            end
            e_evict_dirty = m_dirty[s][w];
            m_dirty[s][w] = 1'b0;
            e_ack = 1'b1;
        end else if (up) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) m_word[s][w][k][b*8 +: 8] = wd[b*8 +: 8];
            m_dirty[s][w] = 1'b1;
            e_ack = 1'b1;
        end else if (rd) begin
            e_rdata = m_word[s][w][k];
            e_rvalid = 1'b1;
        end
        #1;
        chk_eq("rvalid", {127'h0, rvalid}, {127'h0, e_rvalid});
        chk_eq("rdata", {96'h0, rdata}, {96'h0, e_rdata});
        chk_eq("ack", {127'h0, ack}, {127'h0, e_ack});
        chk_eq("busy", {127'h0, busy}, {127'h0, (m_busy_left > 0)});
        chk_eq("evict_dirty", {127'h0, evict_dirty}, {127'h0, e_evict_dirty});
        chk_eq("evict_data", evict_data, e_evict_data);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 128'h0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic w);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, w, 32'h0, 4'h0, 128'h0);
    endtask

    task automatic do_refill(input logic [31:0] a, input logic w, input logic [127:0] dm);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, w, 32'h0, 4'h0, dm);
    endtask

    task automatic do_update(input logic [31:0] a, input logic w, input logic [31:0] wd,
                             input logic [3:0] st);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a, w, wd, st, 128'h0);
    endtask

    task automatic do_clr();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 128'h0);
    endtask

    task automatic do_rst();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 128'h0);
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        m_busy_left = 0;
        e_rdata = 32'h0;
        e_evict_data = 128'h0;
        e_evict_dirty = 1'b0;
        model_zero();

        // Reset, then every set/way/word reads back zero.
        do_rst();
        do_rst();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++)
                for (int k = 0; k < WPL; k++)
                    do_read(32'(s * 16 + k * 4), w[0]);
        idle();

        // Refill set1 way1, then read a word of it.
        do_refill(32'h10, 1'b1, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
        do_read(32'h18, 1'b1);
        chk_eq("read_after_refill", {96'h0, rdata}, {96'h0, 32'h3333_3333});
        idle();

        // Byte-masked update over a known word, then evict it dirty.
        do_refill(32'h10, 1'b0, {32'h0, 32'h0, 32'h1122_3344, 32'h0});
        do_update(32'h14, 1'b0, 32'hAABB_CCDD, 4'b0101);
        do_read(32'h14, 1'b0);
        chk_eq("merged_word", {96'h0, rdata}, {96'h0, 32'h11BB_33DD});
        do_refill(32'h10, 1'b0, 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003);
        chk_eq("evict_dirty_after_update", {127'h0, evict_dirty}, {127'h0, 1'b1});

        // Zero-strobe update still dirties the line.
        do_update(32'h20, 1'b1, 32'hFFFF_FFFF, 4'b0000);
        do_refill(32'h20, 1'b1, 128'h1);

        // Refill and update together: refill wins, update lost.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h24, 1'b0, 32'h5555_5555, 4'hF,
              128'h0A0A_0A0A_0B0B_0B0B_0C0C_0C0C_0D0D_0D0D);
        idle();
        do_read(32'h24, 1'b0);
        do_refill(32'h24, 1'b0, 128'h0);

        // Clear sweep with a read and a refill issued while busy.
        do_update(32'h30, 1'b1, 32'h1234_5678, 4'hF);
        do_clr();
        do_read(32'h10, 1'b1);
        do_refill(32'h30, 1'b1, 128'hFF);
        idle();
        idle();
        idle();
        for (int s = 0; s < NS; s++) do_read(32'(s * 16 + 4), 1'b1);
        do_refill(32'h30, 1'b1, 128'h77);

        // Reset on the second busy cycle of a clear abandons the sweep.
        do_update(32'h00, 1'b0, 32'hCAFE_F00D, 4'hF);
        do_clr();
        idle();
        do_rst();
        do_read(32'h00, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            int op;
            op = int'($urandom_range(0, 99));
            cycle((op == 0), (op >= 1 && op <= 3),
                  (op >= 4 && op <= 40) || ($urandom_range(0, 3) == 0),
                  (op >= 41 && op <= 75) || ($urandom_range(0, 5) == 0),
                  (op >= 76 && op <= 92) || ($urandom_range(0, 7) == 0),
                  $urandom, 1'($urandom), $urandom, 4'($urandom),
                  {$urandom, $urandom, $urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
